cdb_arbiter: RTL and testbench

//  Parametrised common-data-bus arbiter between functional units (alu, multiplier, divider, mem, brAlu) and ROB/RS.

---
 rtl/cdb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/cdb_arbiter.sv | 122 ++++++++++++
 tb/tb_cdb_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared types and helpers for the common-data-bus arbiter and its consumers.
package cdb_pkg;

  localparam int unsigned CDB_DATA_W   = 32;
  localparam int unsigned CDB_ROB_SIZE = 8;
  localparam int unsigned CDB_ROB_IX_W = $clog2(CDB_ROB_SIZE);

  typedef struct packed {
    logic                    valid;
    logic [CDB_ROB_IX_W-1:0] rob_ix;
    logic [CDB_DATA_W-1:0]   value;
  } cdb_msg_t;

  // Index of the set bit in a one-hot vector of up to 32 bits; 0 when empty.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i[4:0]]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: lowest forced request wins, otherwise first request at or after ptr.
module rr_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned N     = 5,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic [N-1:0]     force_vec_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [IDX_W:0] pos;
  logic           found;
  logic [31:0]    gnt_wide;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    pos   = '0;
    if (|force_vec_i) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (force_vec_i[i] && !found) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        pos = {1'b0, ptr_i} + (IDX_W + 1)'(k);
        if (pos >= (IDX_W + 1)'(N)) pos = pos - (IDX_W + 1)'(N);
        if (req_i[pos[IDX_W-1:0]] && !found) begin
          gnt_o[pos[IDX_W-1:0]] = 1'b1;
          found                 = 1'b1;
        end
      end
    end
  end

  assign gnt_wide  = 32'(gnt_o);
  assign gnt_idx_o = IDX_W'(onehot_to_idx(gnt_wide));

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: picks one FU result per cycle, registers the broadcast and
// strobes the winner's read line, with round-robin/fixed priority, aging and flush.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_FU       = 5,
  parameter int unsigned DATA_W       = CDB_DATA_W,
  parameter int unsigned ROB_SIZE     = CDB_ROB_SIZE,
  parameter int unsigned RR_MODE      = 1,
  parameter int unsigned STARVE_LIMIT = 7,
  localparam int unsigned ROB_IX_W    = $clog2(ROB_SIZE),
  localparam int unsigned SRC_W       = $clog2(NUM_FU),
  localparam int unsigned AGE_W       = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       flush_in,
  input  logic [NUM_FU-1:0]          fu_valid_in,
  input  logic [NUM_FU*ROB_IX_W-1:0] fu_rob_ix_in,
  input  logic [NUM_FU*DATA_W-1:0]   fu_data_in,
  output logic [NUM_FU-1:0]          fu_read_out,
  output logic                       cdb_valid_out,
  output logic [ROB_IX_W-1:0]        cdb_rob_ix_out,
  output logic [DATA_W-1:0]          cdb_value_out,
  output logic [SRC_W-1:0]           cdb_src_out
);

  logic [NUM_FU-1:0]   read_q, read_d, elig, force_vec, gnt;
  logic [SRC_W-1:0]    gnt_idx, arb_ptr, ptr_q, ptr_d, src_q, src_d;
  logic                cdb_valid_q, cdb_valid_d, grant_en;
  logic [ROB_IX_W-1:0] rob_ix_q, rob_ix_d, sel_rob_ix;
  logic [DATA_W-1:0]   value_q, value_d, sel_value;
  logic [AGE_W-1:0]    age_q [NUM_FU];
  logic [AGE_W-1:0]    age_d [NUM_FU];

  // An FU still shows valid during its read cycle; mask it so it is not granted twice.
  assign elig    = fu_valid_in & ~read_q;
  assign arb_ptr = (RR_MODE != 0) ? ptr_q : '0;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      force_vec[i] = (STARVE_LIMIT != 0) && elig[i] && (age_q[i] == AGE_W'(STARVE_LIMIT));
    end
  end

  rr_arbiter #(
    .N     (NUM_FU),
    .IDX_W (SRC_W)
  ) u_rr_arbiter (
    .req_i       (elig),
    .ptr_i       (arb_ptr),
    .force_vec_i (force_vec),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx)
  );

  assign grant_en = (|gnt) && !flush_in;

  always_comb begin
    sel_rob_ix = '0;
    sel_value  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (gnt[i]) begin
        sel_rob_ix = fu_rob_ix_in[i*ROB_IX_W +: ROB_IX_W];
        sel_value  = fu_data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    read_d      = grant_en ? gnt : '0;
    cdb_valid_d = grant_en;
    rob_ix_d    = rob_ix_q;
    value_d     = value_q;
    src_d       = src_q;
    ptr_d       = ptr_q;
    if (grant_en) begin
      rob_ix_d = sel_rob_ix;
      value_d  = sel_value;
      src_d    = gnt_idx;
      ptr_d    = (gnt_idx == SRC_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
    end
    // Flush freezes all ages so starving channels keep their standing.
    for (int i = 0; i < NUM_FU; i++) begin
      age_d[i] = age_q[i];
      if (!flush_in) begin
        if (gnt[i] || !fu_valid_in[i]) begin
          age_d[i] = '0;
        end else if (elig[i] && (age_q[i] != AGE_W'(STARVE_LIMIT))) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      read_q      <= '0;
      cdb_valid_q <= 1'b0;
      rob_ix_q    <= '0;
      value_q     <= '0;
      src_q       <= '0;
      ptr_q       <= '0;
      for (int i = 0; i < NUM_FU; i++) age_q[i] <= '0;
    end else begin
      read_q      <= read_d;
      cdb_valid_q <= cdb_valid_d;
      rob_ix_q    <= rob_ix_d;
      value_q     <= value_d;
      src_q       <= src_d;
      ptr_q       <= ptr_d;
      for (int i = 0; i < NUM_FU; i++) age_q[i] <= age_d[i];
    end
  end

  assign fu_read_out    = read_q;
  assign cdb_valid_out  = cdb_valid_q;
  assign cdb_rob_ix_out = rob_ix_q;
  assign cdb_value_out  = value_q;
  assign cdb_src_out    = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: one round-robin instance and one fixed-priority instance.
module tb_cdb_arbiter;

  localparam int NV = 22;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [4:0]   fu_valid;
  logic [14:0]  fu_rob_ix;
  logic [159:0] fu_data;

  logic [4:0]  rr_read, fx_read;
  logic        rr_valid, fx_valid;
  logic [2:0]  rr_rob, fx_rob, rr_src, fx_src;
  logic [31:0] rr_value, fx_value;

  logic [31:0] ch_data [5];
  logic [2:0]  ch_rob  [5];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       rst;
    logic       fx;
    logic [4:0] valid;
    logic       flush;
    logic       ev;
    logic [2:0] es;
    logic [4:0] er;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_FU(5), .DATA_W(32), .ROB_SIZE(8), .RR_MODE(1), .STARVE_LIMIT(7)
  ) dut_rr (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .flush_in       (flush),
    .fu_valid_in    (fu_valid),
    .fu_rob_ix_in   (fu_rob_ix),
    .fu_data_in     (fu_data),
    .fu_read_out    (rr_read),
    .cdb_valid_out  (rr_valid),
    .cdb_rob_ix_out (rr_rob),
    .cdb_value_out  (rr_value),
    .cdb_src_out    (rr_src)
  );

  cdb_arbiter #(
    .NUM_FU(5), .DATA_W(32), .ROB_SIZE(8), .RR_MODE(0), .STARVE_LIMIT(3)
  ) dut_fx (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .flush_in       (flush),
    .fu_valid_in    (fu_valid),
    .fu_rob_ix_in   (fu_rob_ix),
    .fu_data_in     (fu_data),
    .fu_read_out    (fx_read),
    .cdb_valid_out  (fx_valid),
    .cdb_rob_ix_out (fx_rob),
    .cdb_value_out  (fx_value),
    .cdb_src_out    (fx_src)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_channels();
    for (int i = 0; i < 5; i++) begin
      fu_data[i*32 +: 32]  = ch_data[i];
      fu_rob_ix[i*3 +: 3]  = ch_rob[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    fu_valid = '0;
    flush    = 1'b0;
    load_channels();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic [4:0] v, input logic fl);
    @(negedge clk);
    fu_valid = v;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic fx, input logic ev,
                           input logic [2:0] es, input logic [4:0] er);
    logic        v;
    logic [4:0]  rd;
    logic [2:0]  s, rb;
    logic [31:0] val;
    v   = fx ? fx_valid : rr_valid;
    rd  = fx ? fx_read  : rr_read;
    s   = fx ? fx_src   : rr_src;
    rb  = fx ? fx_rob   : rr_rob;
    val = fx ? fx_value : rr_value;
    check({tag, ".valid"}, 32'(v), 32'(ev));
    check({tag, ".read"}, 32'(rd), 32'(er));
    if (ev) begin
      check({tag, ".src"}, 32'(s), 32'(es));
      check({tag, ".rob_ix"}, 32'(rb), 32'(ch_rob[es]));
      check({tag, ".value"}, val, ch_data[es]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    ch_data[0] = 32'h0000_000A; ch_rob[0] = 3'd0;
    ch_data[1] = 32'h0000_1234; ch_rob[1] = 3'd5;
    ch_data[2] = 32'h0000_000C; ch_rob[2] = 3'd2;
    ch_data[3] = 32'h0000_00D3; ch_rob[3] = 3'd3;
    ch_data[4] = 32'h0000_00E4; ch_rob[4] = 3'd4;
    rst_n = 1'b0; flush = 1'b0; fu_valid = '0;
    fu_data = '0; fu_rob_ix = '0;

    //                rst   fx    valid     flush ev    src   read
    // Round-robin, all channels valid: 0,1,2,3,4,0,1 back-to-back.
    vecs[0]  = '{1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 5'b00000};
    vecs[1]  = '{1'b0, 1'b0, 5'b11111, 1'b0, 1'b1, 3'd0, 5'b00001};
    vecs[2]  = '{1'b0, 1'b0, 5'b11111, 1'b0, 1'b1, 3'd1, 5'b00010};
    vecs[3]  = '{1'b0, 1'b0, 5'b11111, 1'b0, 1'b1, 3'd2, 5'b00100};
    vecs[4]  = '{1'b0, 1'b0, 5'b11111, 1'b0, 1'b1, 3'd3, 5'b01000};
    vecs[5]  = '{1'b0, 1'b0, 5'b11111, 1'b0, 1'b1, 3'd4, 5'b10000};
    vecs[6]  = '{1'b0, 1'b0, 5'b11111, 1'b0, 1'b1, 3'd0, 5'b00001};
    vecs[7]  = '{1'b0, 1'b0, 5'b11111, 1'b0, 1'b1, 3'd1, 5'b00010};
    // Fixed priority, ch0/ch2: the read-cycle mask lets ch2 in between ch0 grants.
    vecs[8]  = '{1'b1, 1'b1, 5'b00101, 1'b0, 1'b1, 3'd0, 5'b00001};
    vecs[9]  = '{1'b0, 1'b1, 5'b00101, 1'b0, 1'b1, 3'd2, 5'b00100};
    vecs[10] = '{1'b0, 1'b1, 5'b00101, 1'b0, 1'b1, 3'd0, 5'b00001};
    vecs[11] = '{1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 3'd0, 5'b00000};
    // Fixed priority, ch0/ch1 alternate forever; ch4 ages to 3 and is forced in.
    vecs[12] = '{1'b1, 1'b1, 5'b10011, 1'b0, 1'b1, 3'd0, 5'b00001};
    vecs[13] = '{1'b0, 1'b1, 5'b10011, 1'b0, 1'b1, 3'd1, 5'b00010};
    vecs[14] = '{1'b0, 1'b1, 5'b10011, 1'b0, 1'b1, 3'd0, 5'b00001};
    vecs[15] = '{1'b0, 1'b1, 5'b10011, 1'b0, 1'b1, 3'd4, 5'b10000};
    vecs[16] = '{1'b0, 1'b1, 5'b10011, 1'b0, 1'b1, 3'd0, 5'b00001};
    vecs[17] = '{1'b0, 1'b1, 5'b10011, 1'b0, 1'b1, 3'd1, 5'b00010};
    // Flush for two cycles holds ch1 off the bus; it broadcasts once flush drops.
    vecs[18] = '{1'b1, 1'b0, 5'b00010, 1'b1, 1'b0, 3'd0, 5'b00000};
    vecs[19] = '{1'b0, 1'b0, 5'b00010, 1'b1, 1'b0, 3'd0, 5'b00000};
    vecs[20] = '{1'b0, 1'b0, 5'b00010, 1'b0, 1'b1, 3'd1, 5'b00010};
    vecs[21] = '{1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 5'b00000};

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].valid, vecs[i].flush);
      check_vec($sformatf("vec%0d", i), vecs[i].fx, vecs[i].ev, vecs[i].es, vecs[i].er);
    end

    // Reset state, then asynchronous reset in the middle of a broadcast.
    do_reset();
    #1;
    check("rst.valid", 32'(rr_valid), 32'd0);
    check("rst.read", 32'(rr_read), 32'd0);
    check("rst.value", rr_value, 32'd0);
    check("rst.src", 32'(rr_src), 32'd0);
    step(5'b11111, 1'b0);
    step(5'b11111, 1'b0);
    step(5'b11111, 1'b0);
    check("midrst.pre_src", 32'(rr_src), 32'd2);
    #2;
    rst_n    = 1'b0;
    fu_valid = '0;
    #1;
    check("midrst.valid", 32'(rr_valid), 32'd0);
    check("midrst.read", 32'(rr_read), 32'd0);
    check("midrst.fx_read", 32'(fx_read), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(5'b11111, 1'b0);
    check("midrst.ptr0_src", 32'(rr_src), 32'd0);
    check("midrst.ptr0_read", 32'(rr_read), 32'd1);

    // A broadcast already on the bus is untouched by a flush raised during it.
    do_reset();
    step(5'b00010, 1'b0);
    check("inflight.pre_valid", 32'(rr_valid), 32'd1);
    @(negedge clk);
    fu_valid = 5'b01000;
    flush    = 1'b1;
    #1;
    check("inflight.valid", 32'(rr_valid), 32'd1);
    check("inflight.src", 32'(rr_src), 32'd1);
    @(posedge clk);
    #1;
    check("flushed.valid", 32'(rr_valid), 32'd0);
    check("flushed.read", 32'(rr_read), 32'd0);
    check("flushed.hold_value", rr_value, 32'h0000_1234);
    step(5'b01000, 1'b0);
    check("postflush.src", 32'(rr_src), 32'd3);
    check("postflush.value", rr_value, 32'h0000_00D3);

    // Single FU producing back-to-back results: one broadcast every second cycle.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      fu_data[3*32 +: 32] = 32'hC0DE_0000 + 32'(k / 2);
      step(5'b01000, 1'b0);
      check($sformatf("rapid%0d.valid", k), 32'(rr_valid), 32'(k % 2 == 0));
      check($sformatf("rapid%0d.read", k), 32'(rr_read), (k % 2 == 0) ? 32'h8 : 32'h0);
      check($sformatf("rapid%0d.value", k), rr_value, 32'hC0DE_0000 + 32'(k / 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
